multicycle_control: RTL and testbench

//  Multi-cycle main control FSM for the RISC-V datapath; successor to the single-cycle opcode decoder.

---
 rtl/multicycle_control.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory-ready handshake and timeout.
// Optional ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP instead of retiring as a NOP.
module multicycle_control #(
    parameter int OPCODE_W    = 7,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                branch,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                instr_done,
    output logic                mem_err,
    output logic                illegal,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    // Upper opcode bits must be zero, so compare against zero-extended constants.
    localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_I   = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_LD  = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_SD  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(7'b1100011);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] opc_q, opc_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

    logic       timeout;
    logic       known_op;
    logic       pc_write_c, ir_write_c, alu_src_c, mem_to_reg_c, reg_write_c;
    logic       mem_read_c, mem_write_c, branch_c, instr_done_c, mem_err_c, illegal_c;
    logic [1:0] alu_op_c;

    always_comb begin
        timeout  = (MEM_TIMEOUT != 0) && (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) && !mem_ready;
        known_op = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LD) ||
                   (opcode == OP_SD) || (opcode == OP_BEQ);
    end

    always_comb begin
        state_d      = state_q;
        opc_d        = opc_q;
        wait_cnt_d   = wait_cnt_q;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        alu_src_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        branch_c     = 1'b0;
        instr_done_c = 1'b0;
        mem_err_c    = 1'b0;
        illegal_c    = 1'b0;
        alu_op_c     = 2'b00;

        case (state_q)
            FETCH: begin
                mem_read_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = DECODE;
                end else if (timeout) begin
                    // Refetch from the same PC; only the wait counter restarts.
                    mem_err_c  = 1'b1;
                    wait_cnt_d = '0;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            DECODE: begin
                opc_d = opcode;
                if (known_op) begin
                    state_d = EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = TRAP;
`else
                    state_d      = FETCH;
                    instr_done_c = 1'b1;
`endif
                end
            end
            EXEC: begin
                case (opc_q)
                    OP_R: begin
                        alu_op_c = 2'b10;
                        state_d  = WB;
                    end
                    OP_I: begin
                        alu_op_c  = 2'b11;
                        alu_src_c = 1'b1;
                        state_d   = WB;
                    end
                    OP_LD, OP_SD: begin
                        alu_src_c = 1'b1;
                        state_d   = MEM;
                    end
                    OP_BEQ: begin
                        alu_op_c     = 2'b01;
                        branch_c     = 1'b1;
                        instr_done_c = 1'b1;
                        state_d      = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                mem_read_c  = (opc_q == OP_LD);
                mem_write_c = (opc_q != OP_LD);
                if (mem_ready) begin
                    state_d      = (opc_q == OP_LD) ? WB : FETCH;
                    instr_done_c = (opc_q != OP_LD);
                end else if (timeout) begin
                    mem_err_c = 1'b1;
                    state_d   = FETCH;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = (opc_q == OP_LD);
                instr_done_c = 1'b1;
                state_d      = FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: illegal_c = 1'b1;
`endif
            default: state_d = FETCH;
        endcase

        if (state_d != state_q) wait_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            opc_q      <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Reset masks every output in the same cycle, so an aborted access drops immediately.
    always_comb begin
        pc_write   = reset ? 1'b0 : pc_write_c;
        ir_write   = reset ? 1'b0 : ir_write_c;
        alu_src    = reset ? 1'b0 : alu_src_c;
        mem_to_reg = reset ? 1'b0 : mem_to_reg_c;
        reg_write  = reset ? 1'b0 : reg_write_c;
        mem_read   = reset ? 1'b0 : mem_read_c;
        mem_write  = reset ? 1'b0 : mem_write_c;
        branch     = reset ? 1'b0 : branch_c;
        alu_op     = reset ? '0 : ALUOP_W'(alu_op_c);
        instr_done = reset ? 1'b0 : instr_done_c;
        mem_err    = reset ? 1'b0 : mem_err_c;
        illegal    = reset ? 1'b0 : illegal_c;
        state      = reset ? 3'd0 : state_q;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues hand-computed per-cycle output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'h5a;
    logic       mem_ready = 1'b1;
    logic       pc_write, ir_write, alu_src, mem_to_reg, reg_write;
    logic       mem_read, mem_write, branch, instr_done, mem_err, illegal;
    logic [1:0] alu_op;
    logic [2:0] state;

    multicycle_control #(.OPCODE_W(7), .ALUOP_W(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .alu_src(alu_src),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .alu_op(alu_op),
        .instr_done(instr_done), .mem_err(mem_err), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [10:0] PCW = 11'h400, IRW = 11'h200, ASRC = 11'h100, M2R = 11'h080;
    localparam logic [10:0] RW  = 11'h040, MR  = 11'h020, MW   = 11'h010, BR  = 11'h008;
    localparam logic [10:0] DN  = 11'h004, ERR = 11'h002, ILL  = 11'h001, NONE = 11'h000;

    localparam logic [6:0] OR = 7'h33, OI = 7'h13, OLD = 7'h03, OSD = 7'h23, OBQ = 7'h63;
    localparam logic [6:0] BAD = 7'h7f, J = 7'h5a;

    typedef struct {
        string       name;
        logic [15:0] vec;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic step(input string nm, input logic rst, input logic [6:0] opc, input logic rdy,
                        input logic [2:0] st, input logic [1:0] aop, input logic [10:0] fl);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        opcode    = opc;
        mem_ready = rdy;
        e.name    = nm;
        e.vec     = {st, aop, fl};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e   = q.pop_front();
            act = {state, alu_op, pc_write, ir_write, alu_src, mem_to_reg, reg_write,
                   mem_read, mem_write, branch, instr_done, mem_err, illegal};
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s: got state=%0d aluop=%b flags=%b, want state=%0d aluop=%b flags=%b",
                         e.name, act[15:13], act[12:11], act[10:0],
                         e.vec[15:13], e.vec[12:11], e.vec[10:0]);
            end
        end
    end

    initial begin
        step("rst0", 1, J, 1, 0, 2'b00, NONE);
        step("rst1", 1, J, 1, 0, 2'b00, NONE);

        // R-type, mem_ready held high
        step("r_fetch",  0, J,  1, 0, 2'b00, MR | PCW | IRW);
        step("r_decode", 0, OR, 1, 1, 2'b00, NONE);
        step("r_exec",   0, J,  1, 2, 2'b10, NONE);
        step("r_wb",     0, J,  1, 4, 2'b00, RW | DN);

        // I-type
        step("i_fetch",  0, J,  1, 0, 2'b00, MR | PCW | IRW);
        step("i_decode", 0, OI, 1, 1, 2'b00, NONE);
        step("i_exec",   0, J,  1, 2, 2'b11, ASRC);
        step("i_wb",     0, J,  1, 4, 2'b00, RW | DN);

        // load: two fetch wait cycles, three MEM wait cycles
        for (int k = 0; k < 2; k++) step("ld_fwait", 0, J, 0, 0, 2'b00, MR);
        step("ld_fetch",  0, J,   1, 0, 2'b00, MR | PCW | IRW);
        step("ld_decode", 0, OLD, 1, 1, 2'b00, NONE);
        step("ld_exec",   0, J,   1, 2, 2'b00, ASRC);
        for (int k = 0; k < 3; k++) step("ld_mwait", 0, J, 0, 3, 2'b00, MR);
        step("ld_mem",    0, J,   1, 3, 2'b00, MR);
        step("ld_wb",     0, J,   1, 4, 2'b00, RW | M2R | DN);

        // beq
        step("beq_fetch",  0, J,   1, 0, 2'b00, MR | PCW | IRW);
        step("beq_decode", 0, OBQ, 1, 1, 2'b00, NONE);
        step("beq_exec",   0, J,   1, 2, 2'b01, BR | DN);

        // store timing out in MEM on its fifth wait cycle
        step("sdto_fetch",  0, J,   1, 0, 2'b00, MR | PCW | IRW);
        step("sdto_decode", 0, OSD, 1, 1, 2'b00, NONE);
        step("sdto_exec",   0, J,   1, 2, 2'b00, ASRC);
        for (int k = 0; k < 4; k++) step("sdto_mwait", 0, J, 0, 3, 2'b00, MW);
        step("sdto_err",    0, J,   0, 3, 2'b00, MW | ERR);

        // same store, ready arrives in the would-be timeout cycle
        step("sd_fetch",  0, J,   1, 0, 2'b00, MR | PCW | IRW);
        step("sd_decode", 0, OSD, 1, 1, 2'b00, NONE);
        step("sd_exec",   0, J,   1, 2, 2'b00, ASRC);
        for (int k = 0; k < 4; k++) step("sd_mwait", 0, J, 0, 3, 2'b00, MW);
        step("sd_done",   0, J,   1, 3, 2'b00, MW | DN);

        // fetch timeout: refetch, then complete an R-type
        for (int k = 0; k < 4; k++) step("fto_wait", 0, J, 0, 0, 2'b00, MR);
        step("fto_err",    0, J,  0, 0, 2'b00, MR | ERR);
        step("fto_fetch",  0, J,  1, 0, 2'b00, MR | PCW | IRW);
        step("fto_decode", 0, OR, 1, 1, 2'b00, NONE);
        step("fto_exec",   0, J,  1, 2, 2'b10, NONE);
        step("fto_wb",     0, J,  1, 4, 2'b00, RW | DN);

        // unknown opcode
        step("ill_fetch", 0, J, 1, 0, 2'b00, MR | PCW | IRW);
`ifdef ILLEGAL_TRAP_EN
        step("ill_decode", 0, BAD, 1, 1, 2'b00, NONE);
        step("ill_trap0",  0, J,   1, 5, 2'b00, ILL);
        step("ill_trap1",  0, OR,  0, 5, 2'b00, ILL);
        step("ill_trap2",  0, J,   1, 5, 2'b00, ILL);
        step("ill_reset",  1, J,   1, 0, 2'b00, NONE);
`else
        step("ill_decode", 0, BAD, 1, 1, 2'b00, DN);
`endif

        // reset during a store's MEM wait aborts it
        step("sdr_fetch",  0, J,   1, 0, 2'b00, MR | PCW | IRW);
        step("sdr_decode", 0, OSD, 1, 1, 2'b00, NONE);
        step("sdr_exec",   0, J,   1, 2, 2'b00, ASRC);
        step("sdr_mwait",  0, J,   0, 3, 2'b00, MW);
        step("sdr_reset",  1, J,   0, 0, 2'b00, NONE);
        step("sdr_fwait",  0, J,   0, 0, 2'b00, MR);
        step("sdr_fetch2", 0, J,   1, 0, 2'b00, MR | PCW | IRW);
        step("sdr_decode2",0, OBQ, 1, 1, 2'b00, NONE);
        step("sdr_exec2",  0, J,   1, 2, 2'b01, BR | DN);
        step("sdr_back",   0, J,   0, 0, 2'b00, MR);

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
